button_pio_edge_irq: RTL
========================

// Module: button_pio_edge_irq
// PURPOSE
//  Parametrised Avalon-MM input PIO for push-buttons/switches; successor to the plain 4-bit read-only port.
//  Adds 2-flop synchronisation, per-bit edge capture, per-bit IRQ mask, registered IRQ and optional debounce.
//  Sits between board buttons (Direction buttons, KEY[]) and the Nios II data master / IRQ receiver.
// PARAMETERS
//  WIDTH        4      number of input bits, 1..32
//  EDGE_TYPE    0      0 = falling (active-low press), 1 = rising, 2 = any edge
//  DEB_CYCLES   50000  stable cycles needed before a bit is accepted (used only with debounce compiled in), >=2
//  CNT_W        16     debounce counter width; must hold DEB_CYCLES
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous active-low reset
//  address    in   2      Avalon word address
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data
//  in_port    in   WIDTH  raw asynchronous button inputs
//  readdata   out  32     registered read data
//  irq        out  1      level interrupt, active-high
// BEHAVIOUR
//  Reset: readdata=0, irq=0, edgecapture=0, irqmask=0, sync flops=0, filtered value=0, debounce counters=0.
//  Input path: in_port -> sync1 -> sync2 (2-cycle latency). Filtered value f = sync2 (or debounced sync2).
//  Edge detect: f_d = f delayed 1 cycle; edge[i] = per EDGE_TYPE (fall: f_d&~f, rise: ~f_d&f, any: f_d^f).
//  Register map (32-bit words):
//   0 data        R   {0, f}; writes ignored
//   1 irqmask     RW  bits [WIDTH-1:0]; upper bits read 0
//   2 reserved    R   reads 0; writes ignored
//   3 edgecapture R/W1C  bit set on edge[i]; write 1 clears bit i
//  Reads: readdata <= mux(address) every cycle (chipselect not required); 1-cycle read latency, no wait states.
//  Writes: take effect on the clk edge where chipselect=1 and write_n=0.
//  Simultaneous edge and W1C on the same bit in one cycle: set wins (event never lost).
//  irq <= |(edgecapture & irqmask), registered: asserts 1 cycle after the capture bit sets; deasserts 1 cycle after clear or mask.
//  Masking never clears edgecapture; unmasking a pending bit raises irq next cycle.
//  WIDTH=32: no padding; WIDTH<32: unused readdata bits always 0.
//  Reset mid-operation: all state cleared immediately; first edge after reset is measured from f=0
//   (EDGE_TYPE 1/2 with input held high then sets a capture bit after sync latency).
// CONFIGURATION
//  Macro BUTTON_PIO_DEBOUNCE_EN:
//   defined: per-bit counter; when sync2[i]!=f[i] counter increments, resets to 0 when equal;
//    f[i] toggles when counter reaches DEB_CYCLES-1, counter then clears. Glitches shorter than DEB_CYCLES ignored.
//   undefined: f = sync2; DEB_CYCLES/CNT_W unused; no counters synthesised.
// TESTING
//  1. Reset: reset_n=0 with in_port=4'hF -> readdata=0, irq=0; release, read addr0 after 3 cycles -> 32'h0000000F.
//  2. EDGE_TYPE=0, irqmask=4'b0010, drive in_port 4'hF->4'hD -> edgecapture=4'b0010, irq=1 one cycle later;
//     write 32'h2 to addr3 -> edgecapture=0, irq=0 next cycle.
//  3. Masked edge: irqmask=0, falling edge on bit0 -> edgecapture=1, irq stays 0;
//     write irqmask=1 -> irq=1 next cycle.
//  4. Same-cycle set/clear: bit1 capture pending, W1C 32'h2 in the cycle edge[1] fires -> edgecapture[1] stays 1.
//  5. Debounce (macro defined, DEB_CYCLES=8): 5-cycle low pulse on bit0 -> no data change, no capture;
//     10-cycle low -> data bit0=0 after 2+8 cycles, capture set.
//  6. EDGE_TYPE=2, WIDTH=32: toggle bit31 high then low -> capture set each time; readdata[31] follows.

Source files
------------

// File: rtl/button_pio_edge_irq.sv
// Avalon-MM input PIO: 2-flop sync, per-bit edge capture (W1C), IRQ mask, registered level IRQ.
// Optional per-bit debounce filter compiled in when BUTTON_PIO_DEBOUNCE_EN is defined.
module button_pio_edge_irq #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned EDGE_TYPE  = 0,
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned DW        = 32,
    localparam int unsigned AW        = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [DW-1:0]    writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [DW-1:0]    readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] f_dly_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_bits;

    assign unused_bits = ^{writedata, DEB_CYCLES, CNT_W};

    // Metastability hardening of the raw button lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

`ifdef BUTTON_PIO_DEBOUNCE_EN
    logic [WIDTH-1:0]            filt_q, filt_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // A bit is accepted only after it has differed from the filtered value for DEB_CYCLES cycles
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    always_comb begin
        edge_det = f_dly_q ^ filt;
        if (EDGE_TYPE == 0) begin
            edge_det = f_dly_q & ~filt;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~f_dly_q & filt;
        end
    end

    assign wr_en = chipselect & ~write_n;

    // Register file next state; a new edge overrides a same-cycle W1C so no event is lost
    always_comb begin
        mask_d  = mask_q;
        ecap_d  = ecap_q;
        rdata_d = '0;
        irq_d   = |(ecap_q & mask_q);
        if (wr_en && (address == AW'(1))) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == AW'(3))) begin
            ecap_d = ecap_q & ~writedata[WIDTH-1:0];
        end
        ecap_d = ecap_d | edge_det;
        case (address)
            AW'(0):  rdata_d = DW'(filt);
            AW'(1):  rdata_d = DW'(mask_q);
            AW'(3):  rdata_d = DW'(ecap_q);
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_dly_q <= '0;
            mask_q  <= '0;
            ecap_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            f_dly_q <= filt;
            mask_q  <= mask_d;
            ecap_q  <= ecap_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
